lsu_mem_port: RTL

Load/store front end for the data-side dual-port memory: accepts byte-addressed load/store requests of byte, halfword or word size and converts them into word-addressed, byte-masked accesses on one memory port. Sits between the execute-stage load/store logic and port A of the 512 x 32-bit byte-maskable memory; port B stays free for the other requester. Misaligned accesses that cross a word boundary are split into two sequential memory accesses. Load results are recombined, sign- or zero-extended and returned on a single-cycle response.

---
 rtl/lsu_mem_port.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - byte-addressed load/store front end onto one word-addressed, byte-masked memory port
// Splits word-crossing accesses into two memory cycles and recombines/extends load data.
module lsu_mem_port #(
  parameter int MEM_AW = 9
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [31:0]       i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q, uns_q, err_q;
  logic [1:0]        size_q, offset_q;
  logic [MEM_AW-1:0] word_q;
  logic [63:0]       wdata_q;
  logic [7:0]        mask_q;
  logic [31:0]       lo_q, hi_q;

  logic              accept;
  logic [3:0]        req_mask4;
  logic [31:0]       req_dmask;
  logic [63:0]       req_wdata64;
  logic [7:0]        req_mask8;
  logic [31:0]       shifted;
  logic [31:0]       rsp_data;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^i_req_addr[31:MEM_AW+2];
  assign accept = (state_q == S_IDLE) && i_req_valid;

  // Full-width lane images: low halves go out in ACC1, high halves in ACC2.
  always_comb begin
    req_mask4 = 4'b1111;
    req_dmask = 32'hFFFF_FFFF;
    case (i_req_size)
      2'b00:   begin req_mask4 = 4'b0001; req_dmask = 32'h0000_00FF; end
      2'b01:   begin req_mask4 = 4'b0011; req_dmask = 32'h0000_FFFF; end
      default: begin req_mask4 = 4'b1111; req_dmask = 32'hFFFF_FFFF; end
    endcase
    req_wdata64 = {32'b0, i_req_wdata & req_dmask} << {i_req_addr[1:0], 3'b000};
    req_mask8   = {4'b0, req_mask4} << i_req_addr[1:0];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_req_valid) state_d = (i_req_size == 2'b11) ? S_RESP : S_ACC1;
      S_ACC1: state_d = (mask_q[7:4] != 4'b0) ? S_ACC2 : S_RESP;
      S_ACC2: state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b0;
      offset_q <= 2'b0;
      word_q   <= '0;
      wdata_q  <= 64'b0;
      mask_q   <= 8'b0;
      lo_q     <= 32'b0;
      hi_q     <= 32'b0;
    end else begin
      if (accept) begin
        we_q     <= i_req_we;
        uns_q    <= i_req_unsigned;
        err_q    <= (i_req_size == 2'b11);
        size_q   <= i_req_size;
        offset_q <= i_req_addr[1:0];
        word_q   <= i_req_addr[MEM_AW+1:2];
        wdata_q  <= req_wdata64;
        mask_q   <= req_mask8;
      end
      if (state_q == S_ACC1 && !we_q) lo_q <= i_mem_rdata;
      if (state_q == S_ACC2 && !we_q) hi_q <= i_mem_rdata;
    end
  end

  // Non-crossing loads leave hi_q stale; truncation to nbytes discards it.
  always_comb begin
    shifted  = 32'({hi_q, lo_q} >> {offset_q, 3'b000});
    rsp_data = 32'b0;
    case (size_q)
      2'b00:   rsp_data = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
      2'b01:   rsp_data = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      2'b10:   rsp_data = shifted;
      default: rsp_data = 32'b0;
    endcase
    if (we_q || err_q) rsp_data = 32'b0;
  end

  always_comb begin
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_rsp_rdata = 32'b0;
    o_rsp_err   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = 32'b0;
    o_mem_bmask = 4'b0;
    o_mem_wren  = 1'b0;
    case (state_q)
      S_IDLE: o_req_ready = !i_reset;
      S_ACC1: begin
        o_mem_addr  = word_q;
        o_mem_wdata = wdata_q[31:0];
        o_mem_bmask = mask_q[3:0];
        o_mem_wren  = we_q;
      end
      S_ACC2: begin
        o_mem_addr  = word_q + 1'b1;
        o_mem_wdata = wdata_q[63:32];
        o_mem_bmask = mask_q[7:4];
        o_mem_wren  = we_q;
      end
      default: begin
        o_rsp_valid = 1'b1;
        o_rsp_rdata = rsp_data;
        o_rsp_err   = err_q;
      end
    endcase
  end

endmodule
